aou_issuer: RTL
===============

# aou_issuer

Sequential initiator for the 4-bit arithmetic operations unit (add/sub/mult/div). It accepts one operation request per valid/ready handshake and registers the opcode and operands onto the AOU input bus. After a programmable settle time it captures the AOU result and overflow flag, then returns them on a valid/ready response port. It also screens illegal opcodes and divide-by-zero before the AOU is driven, so the rest of the datapath sees a clocked, flow-controlled arithmetic service.

## Interface
- SETTLE_CYCLES, 1: clock edges between driving the AOU inputs and capturing its outputs; must be ≥1, 0 is an elaboration error
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  issuer can accept a request
- req_op  in  4  opcode: 0110 add, 0111 sub, 1000 mult, 1001 div
- req_a  in  4  operand A
- req_b  in  4  operand B
- aou_op  out  4  registered opcode to AOU
- aou_a  out  4  registered operand A to AOU
- aou_b  out  4  registered operand B to AOU
- aou_y  in  8  AOU result
- aou_v  in  1  AOU overflow flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_y  out  8  result
- rsp_v  out  1  overflow (add/sub only)
- rsp_err  out  1  illegal opcode or divide-by-zero
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, DRIVE, RESP. The reset state is IDLE.
- IDLE: req_ready=1. When req_valid is high at a rising edge, the issuer latches req_op, req_a and req_b.
  - Legal opcode with a nonzero divisor (or a non-div opcode): load aou_op/aou_a/aou_b, load the settle counter with SETTLE_CYCLES, go to DRIVE.
  - Illegal opcode, or opcode 1001 with req_b=0: leave the aou_* outputs unchanged. Load rsp_y=8'h00, rsp_v=0, rsp_err=1, go to RESP.
- DRIVE: the counter decrements on each edge. On the edge where the counter equals 1, capture the result and go to RESP with rsp_err=0:
  - add/sub: rsp_y = {{4{aou_y[3]}}, aou_y[3:0]} (sign-extended nibble); rsp_v = aou_v.
  - mult/div: rsp_y = aou_y unmodified; rsp_v = 0.
- RESP: rsp_valid=1. rsp_y, rsp_v and rsp_err stay stable until rsp_ready is sampled high; the state then returns to IDLE. A response is never dropped or overwritten.
- aou_op/aou_a/aou_b hold their last issued value until the next legal accept.
- req_ready=0 in DRIVE and RESP. Requests offered then are ignored and must be held by the sender.
- rsp_valid, rsp_y, rsp_v and rsp_err are registered. req_ready and busy are decoded from state.

## Timing
- Reset (rst_n low, immediate): state IDLE, req_ready=0 while rst_n is low, busy=0, rsp_valid=0, rsp_y=8'h00, rsp_v=0, rsp_err=0, aou_op=4'b0000, aou_a=0, aou_b=0, counter=0.
- Reset deassert: req_ready=1 in the first cycle after rst_n rises.
- Legal request accepted at edge E0:
  - aou_* are valid after E0.
  - Capture happens at edge E0+SETTLE_CYCLES, and rsp_valid rises after that edge.
- Error request accepted at E0: rsp_valid rises after E0 (1-cycle latency).
- Response handshake at edge Er: rsp_valid falls and req_ready rises after Er. Maximum throughput is one operation per SETTLE_CYCLES+2 cycles.
- rsp_ready held high continuously: the response lasts exactly one cycle.
- rsp_ready high while rsp_valid=0: no effect.
- rst_n asserted in DRIVE or RESP: the operation is aborted, no response is produced, and all outputs go to reset values.

## Test plan
- Reset, SETTLE_CYCLES=1: after rst_n rises, req_ready=1 and busy=0. Request add A=3, B=4 with bench AOU model → aou_op=0110 one cycle after accept; rsp_y=8'h07, rsp_v=0, rsp_err=0 one cycle later.
- Signed overflow: add A=7, B=1 (model y=8'h08, v=1) → rsp_y=8'hF8, rsp_v=1. Sub A=8, B=1 → rsp_y=8'h07, rsp_v=1.
- Mult 15×15 (model y=8'hE1) → rsp_y=8'hE1, rsp_v=0. Model driving aou_v=1 during mult → rsp_v remains 0.
- Div A=9, B=0 → rsp_valid one cycle after accept, rsp_err=1, rsp_y=8'h00, aou_* unchanged. Opcode 0011 → same error response.
- Backpressure, SETTLE_CYCLES=3: rsp_ready low for 5 cycles → rsp_* stable throughout and req_ready=0. A second request offered meanwhile is accepted only on the cycle after the response handshake.
- Reset mid-DRIVE: assert rst_n during a mult → rsp_valid never rises for that mult. The next request after reset completes normally.

Source files
------------

// File: rtl/aou_issuer.sv
// Sequential issuer for the 4-bit AOU: screens requests, drives the AOU, captures result.
// Latency: legal op responds SETTLE_CYCLES edges after accept; illegal/div-by-zero after 1 edge.
// Backpressure: one op in flight; req_ready low until the response is taken, response held stable.
module aou_issuer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic [3:0] aou_op,
    output logic [3:0] aou_a,
    output logic [3:0] aou_b,
    input  logic [7:0] aou_y,
    input  logic       aou_v,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_v,
    output logic       rsp_err,
    output logic       busy
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("aou_issuer: SETTLE_CYCLES must be at least 1");
    end

    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          op_legal;
    logic          div_zero;
    logic          cur_addsub;

    assign op_legal   = (req_op == OP_ADD) || (req_op == OP_SUB) ||
                        (req_op == OP_MULT) || (req_op == OP_DIV);
    assign div_zero   = (req_op == OP_DIV) && (req_b == 4'd0);
    assign cur_addsub = (aou_op == OP_ADD) || (aou_op == OP_SUB);

    // Ready is masked by rst_n so nothing is offered while reset is held.
    assign req_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            aou_op    <= 4'b0000;
            aou_a     <= 4'd0;
            aou_b     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_y     <= 8'h00;
            rsp_v     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (op_legal && !div_zero) begin
                            aou_op <= req_op;
                            aou_a  <= req_a;
                            aou_b  <= req_b;
                            cnt    <= CW'(SETTLE_CYCLES);
                            state  <= DRIVE;
                        end else begin
                            // Rejected ops never touch the AOU bus.
                            rsp_y     <= 8'h00;
                            rsp_v     <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        if (cur_addsub) begin
                            rsp_y <= {{4{aou_y[3]}}, aou_y[3:0]};
                            rsp_v <= aou_v;
                        end else begin
                            rsp_y <= aou_y;
                            rsp_v <= 1'b0;
                        end
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
